// File: rtl/sw_rr_n_if.sv
// sw_rr_n_if: packet bus bundle for the N-port round-robin switch
// in_pkt/out_rdy driven by the master (traffic side), in_full/out_pkt/drop_cnt by the slave (switch)
interface sw_rr_n_if #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int CW = 8
);
    logic [N*W-1:0]  in_pkt;
    logic [N-1:0]    in_full;
    logic [N*W-1:0]  out_pkt;
    logic [N-1:0]    out_rdy;
    logic [N*CW-1:0] drop_cnt;
    modport master (output in_pkt, out_rdy, input in_full, out_pkt, drop_cnt);
    modport slave (input in_pkt, out_rdy, output in_full, out_pkt, drop_cnt);
endinterface

// File: rtl/sw_rr_n.sv
// sw_rr_n: N-port self-routed packet switch, per-input FIFOs, per-output round-robin, registered crossbar
// clk, rst (sync active-high); bus.in_pkt[k*W +: W] inputs, bus.in_full[k] FIFO full,
// bus.out_pkt[j*W +: W] registered outputs, bus.out_rdy[j] grant enable, bus.drop_cnt[k*CW +: CW] saturating drops
module sw_rr_n #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input logic       clk,
    input logic       rst,
    sw_rr_n_if.slave  bus
);
    localparam int PW = $clog2(N);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [N][DEPTH];
    logic [AW-1:0] wp [N];
    logic [AW-1:0] rp [N];
    logic [AW:0]   cnt [N];
    logic [CW-1:0] drops [N];
    logic [PW-1:0] ptr [N];
    logic [W-1:0]  out_q [N];
    logic [W-1:0]  head [N];
    logic [PW-1:0] gi [N];
    logic [N-1:0]  gv, full, nonempty, valid, push, pop;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            head[k]     = mem[k][rp[k]];
            full[k]     = cnt[k] == (AW+1)'(DEPTH);
            nonempty[k] = cnt[k] != '0;
            valid[k]    = bus.in_pkt[k*W+W-1];
            push[k]     = valid[k] && !full[k];
        end
    end

    // Scan from lowest to highest priority so the last hit is the requester nearest ptr+1.
    always_comb begin
        pop = '0;
        for (int j = 0; j < N; j++) begin
            gv[j] = 1'b0;
            gi[j] = ptr[j];
            if (bus.out_rdy[j])
                for (int i = N; i >= 1; i--) begin
                    automatic logic [PW-1:0] idx = ptr[j] + PW'(i);
                    if (nonempty[idx] && head[idx][W-2 -: PW] == PW'(j)) begin
                        gv[j] = 1'b1;
                        gi[j] = idx;
                    end
                end
            if (gv[j]) pop[gi[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                wp[k]    <= '0;
                rp[k]    <= '0;
                cnt[k]   <= '0;
                drops[k] <= '0;
                ptr[k]   <= PW'(N-1);
                out_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (push[k]) begin
                    mem[k][wp[k]] <= bus.in_pkt[k*W +: W];
                    wp[k]         <= wp[k] + 1'b1;
                end
                if (pop[k]) rp[k] <= rp[k] + 1'b1;
                cnt[k] <= cnt[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
                if (valid[k] && full[k] && drops[k] != '1) drops[k] <= drops[k] + 1'b1;
            end
            for (int j = 0; j < N; j++) begin
                out_q[j] <= gv[j] ? head[gi[j]] : '0;
                if (gv[j]) ptr[j] <= gi[j];
            end
        end
    end

    assign bus.in_full = full;

    for (genvar j = 0; j < N; j++) begin : g_out
        assign bus.out_pkt[j*W +: W]    = out_q[j];
        assign bus.drop_cnt[j*CW +: CW] = drops[j];
    end
endmodule

// File: tb/tb_sw_rr_n.sv
// tb_sw_rr_n: directed self-checking bench for sw_rr_n (N=4, W=16, DEPTH=4, CW=2)
module tb_sw_rr_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sw_rr_n_if #(.N(4), .W(16), .CW(2)) bus ();
    sw_rr_n #(.N(4), .W(16), .DEPTH(4), .CW(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] d, input logic [12:0] p);
        return {1'b1, d, p};
    endfunction

    task automatic do_reset();
        bus.in_pkt = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.in_pkt  = '0;
        bus.out_rdy = 4'hF;
        rst = 1'b1;
        // reset with random traffic
        for (int c = 0; c < 2; c++) begin
            bus.in_pkt = {$urandom, $urandom} | 64'h8000_8000_8000_8000;
            tick();
            chk("rst_out", bus.out_pkt, 0);
            chk("rst_full", bus.in_full, 0);
            chk("rst_drop", bus.drop_cnt, 0);
        end
        rst = 1'b0;
        bus.in_pkt = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_out", bus.out_pkt, 0);
            chk("post_rst_full", bus.in_full, 0);
        end
        // single packet, 2-cycle latency
        bus.in_pkt[15:0] = mk(2'd2, 13'h0AB);
        tick();
        bus.in_pkt = '0;
        chk("single_c1", bus.out_pkt, 0);
        tick();
        chk("single_c2", bus.out_pkt, 64'h0000_C0AB_0000_0000);
        chk("single_full", bus.in_full, 0);
        tick();
        chk("single_c3", bus.out_pkt, 0);
        // full contention on dest 1
        for (int k = 0; k < 4; k++) bus.in_pkt[k*16 +: 16] = mk(2'd1, 13'(k + 16));
        tick();
        bus.in_pkt = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("contend", bus.out_pkt, {32'h0, mk(2'd1, 13'(k + 16)), 16'h0});
            tick();
        end
        chk("contend_idle", bus.out_pkt, 0);
        // round robin: inputs 1 and 3 stream to dest 0
        for (int c = 0; c < 20; c++) begin
            bus.in_pkt = '0;
            bus.in_pkt[16 +: 16] = mk(2'd0, {2'd1, 11'(c)});
            bus.in_pkt[48 +: 16] = mk(2'd0, {2'd3, 11'(c)});
            if (c >= 2) chk("rr_src", 64'(bus.out_pkt[15 -: 5]), {59'h0, 3'b100, (c % 2 == 0) ? 2'd1 : 2'd3});
            tick();
        end
        do_reset();
        chk("rr_rst_drop", bus.drop_cnt, 0);
        // backpressure and overflow on input 2 -> dest 3
        bus.out_rdy = 4'h7;
        for (int c = 0; c < 6; c++) begin
            bus.in_pkt = '0;
            bus.in_pkt[32 +: 16] = mk(2'd3, 13'(c + 1));
            chk("bp_full", 64'(bus.in_full[2]), (c >= 4) ? 64'd1 : 64'd0);
            tick();
        end
        bus.in_pkt = '0;
        chk("bp_drop2", 64'(bus.drop_cnt[5:4]), 2);
        chk("bp_out_idle", bus.out_pkt, 0);
        for (int c = 0; c < 3; c++) begin
            bus.in_pkt[32 +: 16] = mk(2'd3, 13'h1F);
            tick();
        end
        bus.in_pkt = '0;
        chk("bp_drop_sat", 64'(bus.drop_cnt[5:4]), 3);
        bus.out_rdy = 4'hF;
        tick();
        chk("bp_full_fall", 64'(bus.in_full[2]), 0);
        for (int k = 1; k <= 4; k++) begin
            chk("bp_drain", bus.out_pkt, {mk(2'd3, 13'(k)), 48'h0});
            tick();
        end
        chk("bp_drain_idle", bus.out_pkt, 0);
        chk("bp_drop_hold", 64'(bus.drop_cnt[5:4]), 3);
        // mid-operation reset flushes buffered packets
        bus.out_rdy = 4'h0;
        for (int c = 0; c < 3; c++) begin
            bus.in_pkt = '0;
            bus.in_pkt[0 +: 16]  = mk(2'd0, 13'(c + 100));
            bus.in_pkt[16 +: 16] = mk(2'd1, 13'(c + 200));
            tick();
        end
        bus.out_rdy = 4'hF;
        do_reset();
        chk("mr_out", bus.out_pkt, 0);
        chk("mr_full", bus.in_full, 0);
        chk("mr_drop", bus.drop_cnt, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mr_stale", bus.out_pkt, 0);
        end
        bus.in_pkt[48 +: 16] = mk(2'd1, 13'h155);
        tick();
        bus.in_pkt = '0;
        chk("mr_fresh_c1", bus.out_pkt, 0);
        tick();
        chk("mr_fresh_c2", bus.out_pkt, {32'h0, 16'hA155, 16'h0});
        tick();
        chk("mr_fresh_c3", bus.out_pkt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
